// File: rtl/apb_gpio_irq_pkg.sv
// Shared register map and reset constants for the APB GPIO interrupt block.
package apb_gpio_pkg;

    localparam logic [7:0] ADDR_DOUT  = 8'h00;
    localparam logic [7:0] ADDR_OE    = 8'h04;
    localparam logic [7:0] ADDR_DIN   = 8'h08;
    localparam logic [7:0] ADDR_EN    = 8'h0C;
    localparam logic [7:0] ADDR_EDGE  = 8'h10;
    localparam logic [7:0] ADDR_POL   = 8'h14;
    localparam logic [7:0] ADDR_BOTH  = 8'h18;
    localparam logic [7:0] ADDR_STAT  = 8'h1C;
    localparam logic [7:0] ADDR_DBCNT = 8'h20;

    localparam logic [7:0] ADDR_MAX   = 8'h20;
    localparam int         DB_CNT_RST = 4;

    // Byte address with the sub-word bits dropped.
    function automatic logic [7:0] word_addr(input logic [7:0] addr);
        return {addr[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/apb_gpio_irq_if.sv
// APB3 slave bus bundle for the GPIO block.
interface apb_gpio_irq_if;

    logic [7:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_gpio_irq_debounce.sv
// Single-bit debouncer: the filtered output only follows the synchronised
// input after it has differed for db_cnt + 1 consecutive cycles.
module gpio_debounce #(
    parameter int DB_W = 8
) (
    input  logic            PCLK,
    input  logic            PRESETN,
    input  logic            s,
    input  logic [DB_W-1:0] db_cnt,
    output logic            f
);

    logic [DB_W-1:0] cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            cnt <= '0;
            f   <= 1'b0;
        end else if (s != f) begin
            // Equality compare: a count already past a newly lowered limit wraps.
            if (cnt == db_cnt) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: input synchroniser and debounce, output/OE registers,
// per-bit edge/level interrupt status with write-1-to-clear.
module apb_gpio_irq
    import apb_gpio_pkg::*;
#(
    parameter int NUM_GPIO    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    apb_gpio_irq_if.slave       apb,
    input  logic [NUM_GPIO-1:0] GPIO_IN,
    output logic [NUM_GPIO-1:0] GPIO_OUT,
    output logic [NUM_GPIO-1:0] GPIO_OE,
    output logic [NUM_GPIO-1:0] INT,
    output logic                INT_OR
);

    typedef logic [NUM_GPIO-1:0] vec_t;

    logic [7:0]      addr;
    logic            wr_en;
    vec_t            wdata;
    vec_t            dout, oe, int_en, int_edge, int_pol, int_both, int_stat;
    logic [DB_W-1:0] db_cnt;
    logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
    vec_t            s, f, f_d, rise, fall, ev, w1c;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign addr        = word_addr(apb.PADDR);
    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign wdata       = apb.PWDATA[NUM_GPIO-1:0];
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], GPIO_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_db
        gpio_debounce #(.DB_W(DB_W)) u_db (
            .PCLK    (PCLK),
            .PRESETN (PRESETN),
            .s       (s[i]),
            .db_cnt  (db_cnt),
            .f       (f[i])
        );
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            f_d <= '0;
        end else begin
            f_d <= f;
        end
    end

    assign rise = f & ~f_d;
    assign fall = ~f & f_d;
    assign ev   = (int_edge & ((int_both & (rise | fall)) |
                               (~int_both & ((int_pol & rise) | (~int_pol & fall))))) |
                  (~int_edge & ((int_pol & f) | (~int_pol & ~f)));
    assign w1c  = (wr_en && addr == ADDR_STAT) ? wdata : '0;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            dout     <= '0;
            oe       <= '0;
            int_en   <= '0;
            int_edge <= '0;
            int_pol  <= '0;
            int_both <= '0;
            int_stat <= '0;
            db_cnt   <= DB_W'(DB_CNT_RST);
        end else begin
            // A new event outranks a clear landing in the same cycle.
            int_stat <= (int_stat & ~w1c) | ev;
            if (wr_en) begin
                case (addr)
                    ADDR_DOUT:  dout     <= wdata;
                    ADDR_OE:    oe       <= wdata;
                    ADDR_EN:    int_en   <= wdata;
                    ADDR_EDGE:  int_edge <= wdata;
                    ADDR_POL:   int_pol  <= wdata;
                    ADDR_BOTH:  int_both <= wdata;
                    ADDR_DBCNT: db_cnt   <= apb.PWDATA[DB_W-1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            INT    <= '0;
            INT_OR <= 1'b0;
        end else begin
            INT    <= int_stat & int_en;
            INT_OR <= |(int_stat & int_en);
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.PSEL) begin
            case (addr)
                ADDR_DOUT:  rdata = 32'(dout);
                ADDR_OE:    rdata = 32'(oe);
                ADDR_DIN:   rdata = 32'(f);
                ADDR_EN:    rdata = 32'(int_en);
                ADDR_EDGE:  rdata = 32'(int_edge);
                ADDR_POL:   rdata = 32'(int_pol);
                ADDR_BOTH:  rdata = 32'(int_both);
                ADDR_STAT:  rdata = 32'(int_stat);
                ADDR_DBCNT: rdata = 32'(db_cnt);
                default:    rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & (addr > ADDR_MAX);
    assign GPIO_OUT    = dout;
    assign GPIO_OE     = oe;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the block.
module tb_apb_gpio_irq;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int DBW  = 8;

    logic         PCLK    = 1'b0;
    logic         PRESETN = 1'b0;
    logic [N-1:0] gpio_in = '0;
    logic [N-1:0] gpio_out, gpio_oe, irq;
    logic         irq_or;

    int checks = 0;
    int errors = 0;

    apb_gpio_irq_if bus ();

    apb_gpio_irq #(.NUM_GPIO(N), .SYNC_STAGES(SYNC), .DB_W(DBW)) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .apb      (bus),
        .GPIO_IN  (gpio_in),
        .GPIO_OUT (gpio_out),
        .GPIO_OE  (gpio_oe),
        .INT      (irq),
        .INT_OR   (irq_or)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- behavioural reference model ----------------
    logic [N-1:0] m_sync [SYNC];
    logic [N-1:0] m_f, m_fd, m_dout, m_oe, m_en, m_edge, m_pol, m_both, m_stat, m_int;
    logic         m_intor;
    int           m_cnt [N];
    int           m_dbcnt;

    task automatic model_step();
        logic [N-1:0] ev, clr, s, nf;
        logic [7:0]   a;
        logic         wr;
        if (!PRESETN) begin
            for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_f = '0; m_fd = '0; m_dout = '0; m_oe = '0; m_en = '0;
            m_edge = '0; m_pol = '0; m_both = '0; m_stat = '0; m_int = '0;
            m_intor = 1'b0; m_dbcnt = 4;
            return;
        end
        s = m_sync[SYNC-1];
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (m_both[i])     ev[i] = (m_f[i] != m_fd[i]);
                else if (m_pol[i]) ev[i] = m_f[i] && !m_fd[i];
                else               ev[i] = !m_f[i] && m_fd[i];
            end else begin
                ev[i] = m_pol[i] ? m_f[i] : !m_f[i];
            end
        end
        wr  = bus.PSEL && bus.PENABLE && bus.PWRITE;
        a   = {bus.PADDR[7:2], 2'b00};
        clr = (wr && a == 8'h1C) ? bus.PWDATA[N-1:0] : '0;
        m_int   = m_stat & m_en;
        m_intor = (m_int != '0);
        m_stat  = (m_stat & ~clr) | ev;
        m_fd    = m_f;
        nf      = m_f;
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_f[i]) begin
                if (m_cnt[i] == m_dbcnt) begin
                    nf[i] = s[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << DBW);
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        m_f = nf;
        for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = gpio_in;
        if (wr) begin
            case (a)
                8'h00: m_dout  = bus.PWDATA[N-1:0];
                8'h04: m_oe    = bus.PWDATA[N-1:0];
                8'h0C: m_en    = bus.PWDATA[N-1:0];
                8'h10: m_edge  = bus.PWDATA[N-1:0];
                8'h14: m_pol   = bus.PWDATA[N-1:0];
                8'h18: m_both  = bus.PWDATA[N-1:0];
                8'h20: m_dbcnt = int'(bus.PWDATA[DBW-1:0]);
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case ({a[7:2], 2'b00})
            8'h00:   return 32'(m_dout);
            8'h04:   return 32'(m_oe);
            8'h08:   return 32'(m_f);
            8'h0C:   return 32'(m_en);
            8'h10:   return 32'(m_edge);
            8'h14:   return 32'(m_pol);
            8'h18:   return 32'(m_both);
            8'h1C:   return 32'(m_stat);
            8'h20:   return 32'(m_dbcnt);
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge PCLK);
        model_step();
    end

    // ---------------- bus drivers ----------------
    task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err,
                            output logic [31:0] exp_rd, output logic exp_err);
        logic [7:0] aw;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #4;
        aw      = {a[7:2], 2'b00};
        rd      = bus.PRDATA;
        err     = bus.PSLVERR;
        exp_rd  = m_read(a);
        exp_err = (aw > 8'h20);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd, erd;
        logic        err, eerr;
        apb_xfer(1'b1, a, d, rd, err, erd, eerr);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] rd, output logic [31:0] erd);
        logic err, eerr;
        apb_xfer(1'b0, a, 32'd0, rd, err, erd, eerr);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd, erd, exp;
        logic        err, eerr;
        logic [7:0]  a;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        for (int k = 0; k <= 8; k++) begin
            a = 8'(k * 4);
            apb_xfer(1'b0, a, 32'd0, rd, err, erd, eerr);
            exp = (a == 8'h20) ? 32'd4 : 32'd0;
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL reset_read addr=%h got=%h want=%h", a, rd, exp);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++; $display("FAIL reset_pslverr addr=%h got=%b want=0", a, err);
            end
        end
        checks++;
        if ({gpio_out, gpio_oe, irq, irq_or} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", {gpio_out, gpio_oe, irq, irq_or});
        end
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
    endtask

    task automatic test_dout_oe();
        logic [31:0] rd, erd;
        logic        err, eerr;
        apb_write(8'h00, 32'hA5);
        checks++;
        if (gpio_out !== 8'hA5) begin
            errors++; $display("FAIL dout_commit got=%h want=a5", gpio_out);
        end
        apb_write(8'h04, 32'h0F);
        checks++;
        if (gpio_oe !== 8'h0F) begin
            errors++; $display("FAIL oe_commit got=%h want=0f", gpio_oe);
        end
        apb_xfer(1'b1, 8'h24, 32'hFFFF_FFFF, rd, err, erd, eerr);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unmapped_pslverr got=%b want=1", err);
        end
        checks++;
        if (gpio_out !== 8'hA5 || gpio_oe !== 8'h0F) begin
            errors++; $display("FAIL unmapped_side_effect out=%h oe=%h want a5/0f", gpio_out, gpio_oe);
        end
        apb_read(8'h00, rd, erd);
        checks++;
        if (rd !== 32'hA5) begin
            errors++; $display("FAIL dout_readback got=%h want=a5", rd);
        end
        apb_read(8'h05, rd, erd);
        checks++;
        if (rd !== 32'h0F) begin
            errors++; $display("FAIL oe_readback got=%h want=0f", rd);
        end
    endtask

    task automatic test_debounce();
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h08;
        gpio_in[0] = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 gpio_in[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge PCLK); #1;
            checks++;
            if (bus.PRDATA[0] !== 1'b0) begin
                errors++; $display("FAIL glitch_din cyc=%0d got=%b want=0", k, bus.PRDATA[0]);
            end
        end
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge PCLK); #1;
            if (k == 6 || k == 7) begin
                checks++;
                if (bus.PRDATA[0] !== (k == 7)) begin
                    errors++; $display("FAIL din_latency cyc=%0d got=%b want=%b", k, bus.PRDATA[0], k == 7);
                end
            end
            checks++;
            if (bus.PRDATA[0] !== m_f[0]) begin
                errors++; $display("FAIL din_model cyc=%0d got=%b want=%b", k, bus.PRDATA[0], m_f[0]);
            end
        end
        gpio_in[0] = 1'b0;
        repeat (10) @(posedge PCLK);
        #1 bus.PSEL = 1'b0;
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd, erd;
        apb_write(8'h10, 32'h04);
        apb_write(8'h14, 32'h04);
        apb_write(8'h0C, 32'h04);
        apb_write(8'h1C, 32'hFF);
        @(posedge PCLK); #1;
        checks++;
        if (irq[2] !== 1'b0 || irq_or !== 1'b0) begin
            errors++; $display("FAIL edge_idle int=%b or=%b want 0/0", irq[2], irq_or);
        end
        gpio_in[2] = 1'b1;
        repeat (12) @(posedge PCLK); #1;
        checks++;
        if (irq[2] !== 1'b1 || irq_or !== 1'b1) begin
            errors++; $display("FAIL edge_rise_int int=%b or=%b want 1/1", irq[2], irq_or);
        end
        apb_write(8'h1C, 32'h04);
        checks++;
        if (irq[2] !== 1'b1) begin
            errors++; $display("FAIL w1c_int_lag got=%b want=1", irq[2]);
        end
        @(posedge PCLK); #1;
        checks++;
        if (irq[2] !== 1'b0 || irq_or !== 1'b0) begin
            errors++; $display("FAIL w1c_int_clear int=%b or=%b want 0/0", irq[2], irq_or);
        end
        gpio_in[2] = 1'b0;
        repeat (12) @(posedge PCLK);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[2] !== 1'b0) begin
            errors++; $display("FAIL edge_fall_ignored got=%b want=0", rd[2]);
        end
        apb_write(8'h18, 32'h04);
        gpio_in[2] = 1'b1;
        repeat (12) @(posedge PCLK);
        apb_write(8'h1C, 32'h04);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[2] !== 1'b0) begin
            errors++; $display("FAIL both_cleared got=%b want=0", rd[2]);
        end
        gpio_in[2] = 1'b0;
        repeat (12) @(posedge PCLK);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[2] !== 1'b1) begin
            errors++; $display("FAIL both_fall_sets got=%b want=1", rd[2]);
        end
        checks++;
        if (rd !== erd) begin
            errors++; $display("FAIL edge_stat_model got=%h want=%h", rd, erd);
        end
    endtask

    task automatic test_level_irq();
        logic [31:0] rd, erd;
        apb_write(8'h1C, 32'h20);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[5] !== 1'b1) begin
            errors++; $display("FAIL level_reassert got=%b want=1", rd[5]);
        end
        gpio_in[5] = 1'b1;
        repeat (12) @(posedge PCLK);
        apb_write(8'h1C, 32'h20);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[5] !== 1'b0) begin
            errors++; $display("FAIL level_inactive_clear got=%b want=0", rd[5]);
        end
        checks++;
        if (rd !== erd) begin
            errors++; $display("FAIL level_stat_model got=%h want=%h", rd, erd);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd, erd;
        apb_write(8'h10, 32'h06);
        apb_write(8'h14, 32'h06);
        apb_write(8'h1C, 32'h02);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[1] !== 1'b0) begin
            errors++; $display("FAIL set_wins_pre got=%b want=0", rd[1]);
        end
        @(posedge PCLK); #1;
        gpio_in[1] = 1'b1;
        repeat (5) @(posedge PCLK);
        apb_write(8'h1C, 32'h02);
        apb_read(8'h1C, rd, erd);
        checks++;
        if (rd[1] !== 1'b1) begin
            errors++; $display("FAIL set_wins got=%b want=1", rd[1]);
        end
        checks++;
        if (rd !== erd) begin
            errors++; $display("FAIL set_wins_model got=%h want=%h", rd, erd);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge PCLK); #1;
        gpio_in[3] = 1'b1;
        repeat (4) @(posedge PCLK);
        #1 PRESETN = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if (dut.g_db[3].u_db.cnt !== '0 || dut.g_db[3].u_db.f !== 1'b0) begin
            errors++; $display("FAIL rst_mid_db cnt=%h f=%b want 0/0",
                               dut.g_db[3].u_db.cnt, dut.g_db[3].u_db.f);
        end
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h1C;
        #1;
        checks++;
        if (bus.PRDATA !== 32'd0 || irq !== '0 || irq_or !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stat stat=%h int=%h or=%b want 0", bus.PRDATA, irq, irq_or);
        end
        bus.PADDR = 8'h08;
        PRESETN = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge PCLK); #1;
            if (k >= 6) begin
                checks++;
                if (bus.PRDATA[3] !== (k == 7)) begin
                    errors++; $display("FAIL rst_mid_restart cyc=%0d got=%b want=%b", k, bus.PRDATA[3], k == 7);
                end
            end
        end
        bus.PSEL = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, d;
        logic        err, eerr;
        logic [7:0]  a;
        int          op, idx;
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                idx = $urandom_range(0, N - 1);
                gpio_in[idx] = ~gpio_in[idx];
            end
            op = $urandom_range(0, 9);
            a  = 8'($urandom_range(0, 15) * 4) | 8'($urandom_range(0, 3));
            d  = $urandom;
            if ({a[7:2], 2'b00} == 8'h20) d = 32'($urandom_range(0, 6));
            if (op <= 7) begin
                apb_xfer(op <= 4, a, d, rd, err, erd, eerr);
                checks++;
                if (err !== eerr) begin
                    errors++; $display("FAIL rnd_pslverr addr=%h got=%b want=%b", a, err, eerr);
                end
                if (op > 4) begin
                    checks++;
                    if (rd !== erd) begin
                        errors++; $display("FAIL rnd_rdata addr=%h got=%h want=%h", a, rd, erd);
                    end
                end
            end else begin
                @(posedge PCLK); #1;
            end
            checks++;
            if (gpio_out !== m_dout || gpio_oe !== m_oe) begin
                errors++; $display("FAIL rnd_pins out=%h oe=%h want %h/%h", gpio_out, gpio_oe, m_dout, m_oe);
            end
            checks++;
            if (irq !== m_int || irq_or !== m_intor) begin
                errors++; $display("FAIL rnd_int int=%h or=%b want %h/%b", irq, irq_or, m_int, m_intor);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dout_oe();
        test_debounce();
        test_edge_irq();
        test_level_irq();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
